// File: rtl/fpnew_pkg.sv
// Shared FP format and special-value kind definitions.
// Formats, per-format field widths and result kinds.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  localparam int NUM_FP_FORMATS = 5;

  typedef struct packed {
    int exp_bits;
    int man_bits;
  } fp_encoding_t;

  localparam fp_encoding_t FP_ENCODINGS [NUM_FP_FORMATS] = '{
    '{8, 23},
    '{11, 52},
    '{5, 10},
    '{5, 2},
    '{8, 7}
  };

  typedef enum logic [1:0] {
    QNAN    = 2'd0,
    INF     = 2'd1,
    ZERO    = 2'd2,
    MAXNORM = 2'd3
  } kind_e;

  // Unknown format codes map to an all-zero encoding.
  function automatic fp_encoding_t fmt_encoding(logic [2:0] fmt);
    fmt_encoding = '0;
    for (int f = 0; f < NUM_FP_FORMATS; f++) begin
      if (int'(fmt) == f) fmt_encoding = FP_ENCODINGS[f];
    end
  endfunction

endpackage

// File: rtl/fpnew_pipe_reg.sv
// One elastic pipeline stage: valid bit, data register, handshake.
// Loads when empty or when downstream drains it in the same cycle.
module fpnew_pipe_reg #(
  parameter int DW = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  assign in_ready_o  = ~valid_q | out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_valid_i && in_ready_o) data_q <= in_data_i;
  end

endmodule

// File: rtl/fpnew_special_pipe.sv
// Special-value (qNaN/Inf/zero/max-normal) encoder with elastic pipe.
// Define FPNEW_NANBOX_EN to fill bits above the format width with ones.
module fpnew_special_pipe
  import fpnew_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int NUM_REGS  = 2,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2:0]           fmt_i,
  input  logic [1:0]           kind_i,
  input  logic                 sign_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     result_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic                 illegal_o,
  output logic                 busy_o
);

  localparam int DW = WIDTH + TAG_WIDTH + 1;

  fp_encoding_t     enc;
  int               m;
  int               e;
  int               w;
  logic             illegal;
  logic [WIDTH-1:0] result;
  logic [DW-1:0]    in_data;
  logic [DW-1:0]    out_data;

  // Fields sit at [m-1:0] mantissa, [m+e-1:m] exponent, [m+e] sign.
  always_comb begin
    enc     = fmt_encoding(fmt_i);
    m       = enc.man_bits;
    e       = enc.exp_bits;
    w       = 1 + e + m;
    illegal = (fmt_i > FP16ALT) || (w > WIDTH);
    result  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (kind_e'(kind_i))
        QNAN:
          result[i] = (i >= m && i < m + e) || (i == m - 1);
        INF:
          result[i] = (i >= m && i < m + e) || (i == m + e && sign_i);
        ZERO:
          result[i] = (i == m + e) && sign_i;
        MAXNORM:
          result[i] = (i < m) || (i > m && i < m + e)
                    || (i == m + e && sign_i);
      endcase
`ifdef FPNEW_NANBOX_EN
      if (i >= w) result[i] = 1'b1;
`endif
    end
    if (illegal) result = '0;
  end

  assign in_data = {illegal, tag_i, result};

  generate
    if (NUM_REGS == 0) begin : g_comb
      assign out_valid_o = in_valid_i;
      assign in_ready_o  = out_ready_i;
      assign out_data    = in_data;
      assign busy_o      = 1'b0;
    end else begin : g_pipe
      logic [NUM_REGS:0] valid;
      logic [NUM_REGS:0] ready;
      logic [DW-1:0]     data [NUM_REGS+1];

      assign valid[0]        = in_valid_i;
      assign in_ready_o      = ready[0];
      assign data[0]         = in_data;
      assign ready[NUM_REGS] = out_ready_i;
      assign out_valid_o     = valid[NUM_REGS];
      assign out_data        = data[NUM_REGS];
      assign busy_o          = |valid[NUM_REGS:1];

      for (genvar s = 0; s < NUM_REGS; s++) begin : g_stage
        fpnew_pipe_reg #(
          .DW(DW)
        ) u_reg (
          .clk_i      (clk_i),
          .rst_ni     (rst_ni),
          .flush_i    (flush_i),
          .in_valid_i (valid[s]),
          .in_ready_o (ready[s]),
          .in_data_i  (data[s]),
          .out_valid_o(valid[s+1]),
          .out_ready_i(ready[s+1]),
          .out_data_o (data[s+1])
        );
      end
    end
  endgenerate

  assign {illegal_o, tag_o, result_o} = out_data;

endmodule
